// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : Decode-side and memory-side signal bundle for fetch_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_sequencer_if;
  logic        stall_i;
  logic        branch_valid_i;
  logic [7:0]  branch_target_i;
  logic        mem_req_o;
  logic [7:0]  mem_addr_o;
  logic        mem_ack_i;
  logic [15:0] mem_rdata_i;
  logic        ir_valid_o;
  logic [15:0] ir_o;
  logic [7:0]  ir_pc_o;
  logic        fetch_err_o;

  modport master (
    input  stall_i, branch_valid_i, branch_target_i, mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, ir_valid_o, ir_o, ir_pc_o, fetch_err_o
  );

  modport slave (
    output stall_i, branch_valid_i, branch_target_i, mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, ir_valid_o, ir_o, ir_pc_o, fetch_err_o
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Single-outstanding instruction fetch FSM with branch redirect;
//            optional memory timeout enabled by macro FETCH_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned TIMEOUT  = 15
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_HOLD    = 3'd2,
`ifdef FETCH_TIMEOUT_EN
    S_DISCARD = 3'd3,
    S_ERROR   = 3'd4
`else
    S_DISCARD = 3'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  ir_pc_q, ir_pc_d;
  logic        armed_q;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] c_TMO_LAST = 4'(TIMEOUT - 1);
  logic       fetch_err_q, fetch_err_d;
  logic [3:0] tmo_q, tmo_d;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 8'h00;
      ir_valid_q  <= 1'b0;
      ir_q        <= 16'h0000;
      ir_pc_q     <= 8'h00;
      armed_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_q <= 1'b0;
      tmo_q       <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ir_valid_q  <= ir_valid_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      armed_q     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_q <= fetch_err_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  // IDLE waits one armed cycle so the first request rises on the second edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_valid_d = ir_valid_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
`ifdef FETCH_TIMEOUT_EN
    fetch_err_d = fetch_err_q;
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (bus.branch_valid_i) begin
          ir_valid_d = 1'b0;
          pc_d       = bus.branch_target_i;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.branch_target_i;
          state_d    = S_REQ;
        end else if ((state_q == S_IDLE && armed_q) ||
                     (state_q == S_HOLD && !bus.stall_i)) begin
          ir_valid_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ack_i) begin
          if (bus.branch_valid_i) begin
            pc_d       = bus.branch_target_i;
            mem_addr_d = bus.branch_target_i;
          end else begin
            ir_d       = bus.mem_rdata_i;
            ir_pc_d    = mem_addr_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 8'd1;
            mem_req_d  = 1'b0;
            state_d    = S_HOLD;
          end
        end else if (bus.branch_valid_i) begin
          pc_d    = bus.branch_target_i;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.branch_valid_i) begin
          pc_d = bus.branch_target_i;
        end
        if (bus.mem_ack_i) begin
          mem_addr_d = bus.branch_valid_i ? bus.branch_target_i : pc_q;
          state_d    = S_REQ;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERROR: begin
        state_d = S_ERROR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef FETCH_TIMEOUT_EN
    // A new request starts on a rising req or on an ack that keeps req high.
    if (mem_req_d && (!mem_req_q || bus.mem_ack_i)) begin
      tmo_d = 4'h0;
    end else if (mem_req_q && !bus.mem_ack_i) begin
      tmo_d = tmo_q + 4'h1;
      if (tmo_q == c_TMO_LAST) begin
        fetch_err_d = 1'b1;
        mem_req_d   = 1'b0;
        ir_valid_d  = 1'b0;
        state_d     = S_ERROR;
      end
    end
`endif
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.ir_valid_o  = ir_valid_q;
  assign bus.ir_o        = ir_q;
  assign bus.ir_pc_o     = ir_pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err_o = fetch_err_q;
`else
  assign bus.fetch_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, the PC loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, the number of no-ack cycles before a fetch error; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  downstream cannot accept ir this cycle.
REQ-006 branch_valid  in  1  one-cycle redirect request.
REQ-007 branch_target  in  8  redirect address.
REQ-008 mem_req  out  1  instruction memory request, registered.
REQ-009 mem_addr  out  8  request address, registered.
REQ-010 mem_ack  in  1  memory returns mem_rdata this cycle.
REQ-011 mem_rdata  in  16  instruction word.
REQ-012 ir_valid  out  1  ir holds an instruction for the decode stage.
REQ-013 ir  out  16  fetched instruction.
REQ-014 ir_pc  out  8  address of ir.
REQ-015 fetch_err  out  1  sticky memory timeout flag.

Function
REQ-016 The FSM SHALL use the states IDLE, REQ, HOLD and DISCARD, plus ERROR when FETCH_TIMEOUT_EN is defined.
REQ-017 IDLE SHALL go to REQ the next cycle, asserting mem_req=1 and mem_addr=pc.
REQ-018 In REQ and DISCARD, mem_req SHALL be 1 and mem_addr SHALL be held stable until the cycle mem_ack is sampled 1; a request is never withdrawn.
REQ-019 In REQ on mem_ack without a branch, the block SHALL load ir<=mem_rdata, ir_pc<=mem_addr and ir_valid<=1, set pc<=pc+1 (8'hFF wraps to 8'h00), drop mem_req to 0, and go to HOLD.
REQ-020 In HOLD with stall=1, ir, ir_pc and ir_valid SHALL remain unchanged.
REQ-021 In HOLD with stall=0, ir SHALL be consumed at that edge: ir_valid<=0, mem_req<=1, mem_addr<=pc, and the FSM goes to REQ. Peak throughput is one instruction per two cycles.
REQ-022 branch_valid SHALL have priority over stall and over normal sequencing.
REQ-023 On a branch in IDLE or HOLD: ir_valid<=0, pc<=branch_target, mem_req<=1, mem_addr<=branch_target, and the FSM goes to REQ.
REQ-024 On a branch in REQ with mem_ack=1 in the same cycle: the returned data SHALL be dropped (ir_valid stays 0), mem_addr<=branch_target, pc<=branch_target, mem_req stays 1, and the FSM stays in REQ.
REQ-025 On a branch in REQ with mem_ack=0: pc<=branch_target, mem_addr is unchanged, and the FSM goes to DISCARD.
REQ-026 In DISCARD, a further branch SHALL update pc to the newest target.
REQ-027 In DISCARD, on mem_ack the data SHALL be dropped, mem_addr<=pc (the newest target), and the FSM goes to REQ.
REQ-028 The block SHALL accept no more than one outstanding memory request at any time.
REQ-029 ir_valid SHALL be 0 in IDLE, REQ and DISCARD.

Reset
REQ-030 While rst=0, outputs SHALL be forced immediately regardless of clk: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=8'h00, ir_valid=0, ir=16'h0000, ir_pc=8'h00, fetch_err=0, timeout counter=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; a mem_ack arriving after release and before the first new request SHALL be ignored.
REQ-032 The first mem_req SHALL rise on the second rising edge after rst deasserts.

Configuration
REQ-033 With macro FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL clear whenever a request starts and increment on each cycle with mem_req=1 and mem_ack=0.
REQ-034 With FETCH_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL set fetch_err<=1, mem_req<=0 and ir_valid<=0, and enter ERROR.
REQ-035 ERROR SHALL ignore branch_valid and mem_ack and is left only by reset.
REQ-036 Without FETCH_TIMEOUT_EN, fetch_err SHALL be tied 0, no counter or ERROR state is built, and REQ/DISCARD wait indefinitely.

Verification
REQ-037 Release reset with mem_ack=1 every cycle and stall=0 -> ir_pc sequence 00,01,02,... with ir_valid high every second cycle and ir equal to mem_rdata of that address.
REQ-038 pc=8'hFF fetched -> next mem_addr=8'h00.
REQ-039 Hold stall=1 for 5 cycles in HOLD -> ir and ir_pc stable and mem_req=0 throughout; after stall drops, mem_req rises on the next edge.
REQ-040 branch_target=8'h40 while in REQ, mem_ack delayed 3 cycles -> DISCARD state, old data never reaches ir_valid, next mem_addr=8'h40, and ir_pc=8'h40 follows.
REQ-041 branch with mem_ack in the same cycle, target 8'h10 -> mem_req stays high with mem_addr=8'h10 and no ir_valid pulse.
REQ-042 FETCH_TIMEOUT_EN defined, TIMEOUT=15, mem_ack held 0 -> fetch_err=1 after the 15th waiting cycle, mem_req=0; a later branch has no effect; rst pulse clears fetch_err.
